// File: rtl/i2p_pkg.sv
// Shared definitions for the infix-to-postfix converter: token codes,
// FSM state encoding and operator precedence.
package i2p_pkg;

    localparam logic [7:0] TOK_LPAREN = 8'h28;
    localparam logic [7:0] TOK_RPAREN = 8'h29;
    localparam logic [7:0] TOK_MUL    = 8'h2A;
    localparam logic [7:0] TOK_ADD    = 8'h2B;
    localparam logic [7:0] TOK_SUB    = 8'h2D;
    localparam logic [7:0] TOK_DIV    = 8'h2F;
    localparam logic [7:0] TOK_END    = 8'h3D;
    localparam logic [7:0] TOK_ERR    = 8'h3F;

    typedef enum logic [2:0] {
        ST_ACCEPT,
        ST_REDUCE,
        ST_CLOSE,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    // '(' and anything that is not an arithmetic operator rank lowest, which
    // makes a stacked '(' act as a barrier during reduction.
    function automatic logic [1:0] prec(input logic [7:0] tok);
        case (tok)
            TOK_MUL, TOK_DIV: prec = 2'd2;
            TOK_ADD, TOK_SUB: prec = 2'd1;
            default:          prec = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/infix_to_postfix_stack.sv
// 8-bit operator stack. Entry 0 is never written, so the stack pointer
// doubles as the occupancy count and sp==0 means empty. Top of stack and
// empty are combinational. flush wins over pop, pop wins over push.
module infix_to_postfix_stack #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] push_data,
    output logic [7:0] top,
    output logic       empty
);

    localparam logic [DEPTH_LOG2-1:0] SP_FULL = '1;
    localparam logic [DEPTH_LOG2-1:0] SP_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem_q [1<<DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] sp_q, sp_d;
    logic [DEPTH_LOG2-1:0] sp_inc;
    logic                  do_push;
    logic                  do_pop;

    assign sp_inc  = sp_q + SP_ONE;
    assign do_pop  = !flush && pop && (sp_q != '0);
    assign do_push = !flush && !pop && push && (sp_q != SP_FULL);
    assign top     = mem_q[sp_q];
    assign empty   = (sp_q == '0);

    // Next stack pointer from the single permitted operation.
    always_comb begin
        sp_d = sp_q;
        if (flush) begin
            sp_d = '0;
        end else if (do_pop) begin
            sp_d = sp_q - SP_ONE;
        end else if (do_push) begin
            sp_d = sp_inc;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage write; contents need no reset since sp guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_inc] <= push_data;
        end
    end

endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter feeding the postfix evaluator.
// Build option: define I2P_ERR_CHECK_EN to add the sticky o_err flag and to
// mark a faulty expression with a '?' end token instead of '='.
module infix_to_postfix
    import i2p_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic       i_is_num,
    input  logic [7:0] i_data,
    output logic       i_ready,
    output logic       o_valid,
    output logic       o_is_num,
    output logic [7:0] o_data,
    input  logic       o_ready,
    output logic       o_busy
`ifdef I2P_ERR_CHECK_EN
    ,
    output logic       o_err
`endif
);

    localparam logic [DEPTH_LOG2-1:0] DEPTH_FULL = '1;
    localparam logic [DEPTH_LOG2-1:0] DEPTH_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [7:0]            pend_op_q, pend_op_d;
    logic [DEPTH_LOG2-1:0] depth_q, depth_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_is_num_q, o_is_num_d;
    logic [7:0]            o_data_q, o_data_d;
    logic                  rdy_en_q;

    logic                  stk_push, stk_pop, stk_flush;
    logic [7:0]            stk_push_data;
    logic [7:0]            stk_top;
    logic                  stk_empty;

    logic                  slot_free;
    logic                  stack_full;
    logic                  reduce_hit;
    logic [7:0]            end_tok;

`ifdef I2P_ERR_CHECK_EN
    logic                  err_q, err_d;
    logic                  end_q, end_d;
    logic                  err_set;

    assign o_err   = err_q;
    assign end_tok = err_q ? TOK_ERR : TOK_END;
`else
    assign end_tok = TOK_END;
`endif

    assign slot_free  = !o_valid_q || o_ready;
    assign stack_full = (depth_q == DEPTH_FULL);
    assign reduce_hit = !stk_empty && (stk_top != TOK_LPAREN)
                        && (prec(stk_top) >= prec(pend_op_q));

    assign i_ready  = rdy_en_q && (state_q == ST_ACCEPT) && slot_free;
    assign o_valid  = o_valid_q;
    assign o_is_num = o_is_num_q;
    assign o_data   = o_data_q;
    assign o_busy   = (state_q != ST_ACCEPT) || !stk_empty;

    // Conversion step: next state, output slot load and stack command.
    always_comb begin
        state_d       = state_q;
        pend_op_d     = pend_op_q;
        depth_d       = depth_q;
        o_valid_d     = o_valid_q && !o_ready;
        o_is_num_d    = o_is_num_q;
        o_data_d      = o_data_q;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_flush     = 1'b0;
        stk_push_data = pend_op_q;
`ifdef I2P_ERR_CHECK_EN
        err_set       = 1'b0;
        end_d         = end_q && !(o_valid_q && o_ready);
`endif
        case (state_q)
            ST_ACCEPT: begin
                if (i_valid && i_ready) begin
                    if (i_is_num) begin
                        o_valid_d  = 1'b1;
                        o_is_num_d = 1'b1;
                        o_data_d   = i_data;
                    end else begin
                        case (i_data)
                            TOK_LPAREN: begin
                                if (stack_full) begin
`ifdef I2P_ERR_CHECK_EN
                                    err_set = 1'b1;
`endif
                                end else begin
                                    stk_push      = 1'b1;
                                    stk_push_data = i_data;
                                    depth_d       = depth_q + DEPTH_ONE;
                                end
                            end
                            TOK_ADD, TOK_SUB, TOK_MUL, TOK_DIV: begin
                                pend_op_d = i_data;
                                state_d   = ST_REDUCE;
                            end
                            TOK_RPAREN: state_d = ST_CLOSE;
                            TOK_END:    state_d = ST_DRAIN;
                            default:    ;
                        endcase
                    end
                end
            end
            ST_REDUCE: begin
                if (reduce_hit) begin
                    if (slot_free) begin
                        o_valid_d  = 1'b1;
                        o_is_num_d = 1'b0;
                        o_data_d   = stk_top;
                        stk_pop    = 1'b1;
                        depth_d    = depth_q - DEPTH_ONE;
                    end
                end else begin
                    if (stack_full) begin
`ifdef I2P_ERR_CHECK_EN
                        err_set = 1'b1;
`endif
                    end else begin
                        stk_push = 1'b1;
                        depth_d  = depth_q + DEPTH_ONE;
                    end
                    state_d = ST_ACCEPT;
                end
            end
            ST_CLOSE: begin
                if (stk_empty) begin
`ifdef I2P_ERR_CHECK_EN
                    err_set = 1'b1;
`endif
                    state_d = ST_ACCEPT;
                end else if (stk_top == TOK_LPAREN) begin
                    stk_pop = 1'b1;
                    depth_d = depth_q - DEPTH_ONE;
                    state_d = ST_ACCEPT;
                end else if (slot_free) begin
                    o_valid_d  = 1'b1;
                    o_is_num_d = 1'b0;
                    o_data_d   = stk_top;
                    stk_pop    = 1'b1;
                    depth_d    = depth_q - DEPTH_ONE;
                end
            end
            ST_DRAIN: begin
                if (stk_empty) begin
                    state_d = ST_FINISH;
                end else if (stk_top == TOK_LPAREN) begin
`ifdef I2P_ERR_CHECK_EN
                    err_set = 1'b1;
`endif
                    stk_pop = 1'b1;
                    depth_d = depth_q - DEPTH_ONE;
                end else if (slot_free) begin
                    o_valid_d  = 1'b1;
                    o_is_num_d = 1'b0;
                    o_data_d   = stk_top;
                    stk_pop    = 1'b1;
                    depth_d    = depth_q - DEPTH_ONE;
                end
            end
            ST_FINISH: begin
                if (slot_free) begin
                    o_valid_d  = 1'b1;
                    o_is_num_d = 1'b0;
                    o_data_d   = end_tok;
                    stk_flush  = 1'b1;
                    depth_d    = '0;
                    state_d    = ST_ACCEPT;
`ifdef I2P_ERR_CHECK_EN
                    end_d      = 1'b1;
`endif
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
`ifdef I2P_ERR_CHECK_EN
        // The flag stays visible until the end token carrying it is taken.
        err_d = err_q;
        if (o_valid_q && o_ready && end_q) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
`endif
    end

    // FSM, output slot and depth counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCEPT;
            pend_op_q  <= 8'h00;
            depth_q    <= '0;
            o_valid_q  <= 1'b0;
            o_is_num_q <= 1'b0;
            o_data_q   <= 8'h00;
            rdy_en_q   <= 1'b0;
`ifdef I2P_ERR_CHECK_EN
            err_q      <= 1'b0;
            end_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pend_op_q  <= pend_op_d;
            depth_q    <= depth_d;
            o_valid_q  <= o_valid_d;
            o_is_num_q <= o_is_num_d;
            o_data_q   <= o_data_d;
            rdy_en_q   <= 1'b1;
`ifdef I2P_ERR_CHECK_EN
            err_q      <= err_d;
            end_q      <= end_d;
`endif
        end
    end

    infix_to_postfix_stack #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (stk_push),
        .pop      (stk_pop),
        .flush    (stk_flush),
        .push_data(stk_push_data),
        .top      (stk_top),
        .empty    (stk_empty)
    );

endmodule

// File: tb/tb_infix_to_postfix.sv
// Scoreboard bench for infix_to_postfix. Random expressions are built as
// expression trees; the infix stream is an in-order walk with the
// parentheses the tree needs (plus some redundant ones) and the expected
// postfix stream is the post-order walk of the same tree.
module tb_infix_to_postfix;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       i_is_num;
    logic [7:0] i_data;
    logic       i_ready;
    logic       o_valid;
    logic       o_is_num;
    logic [7:0] o_data;
    logic       o_ready;
    logic       o_busy;
`ifdef I2P_ERR_CHECK_EN
    logic       o_err;
    localparam logic [7:0] BAD_END = 8'h3F;
`else
    localparam logic [7:0] BAD_END = 8'h3D;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rdy_mode = 0;
    logic [8:0] exp_q[$];

    infix_to_postfix dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_is_num(i_is_num),
        .i_data  (i_data),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_is_num(o_is_num),
        .o_data  (o_data),
        .o_ready (o_ready),
        .o_busy  (o_busy)
`ifdef I2P_ERR_CHECK_EN
        ,
        .o_err   (o_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tprec(input byte unsigned op);
        return (op == 8'h2A || op == 8'h2F) ? 2 : 1;
    endfunction

    // Downstream ready: steady, the 1,0,0,1 pattern, or random.
    initial begin
        int  c;
        bit [3:0] pat;
        c = 0;
        pat = 4'b1001;
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: o_ready = 1'b1;
                1: begin
                    o_ready = pat[3 - (c % 4)];
                    c++;
                end
                default: o_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks that
    // a stalled token is held unchanged.
    initial begin
        logic       hold;
        logic [8:0] held;
        logic [8:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_stable", {23'd0, o_valid, o_is_num, o_data}, {23'd0, 1'b1, held});
                end
                if (o_valid && o_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_token: got is_num=%0d data=0x%0h, expected none",
                                 o_is_num, o_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_token", {23'd0, o_is_num, o_data}, {23'd0, e});
                    end
                    hold = 1'b0;
                end else if (o_valid) begin
                    hold = 1'b1;
                    held = {o_is_num, o_data};
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic push_expected(input string pd, input string pk, input logic [7:0] endtok);
        logic [8:0] e;
        for (int i = 0; i < pd.len(); i++) begin
            e = {(pk[i] == 8'h6E), pd[i]};
            exp_q.push_back(e);
        end
        exp_q.push_back({1'b0, endtok});
    endtask

    task automatic drive_tok(input logic num, input logic [7:0] d);
        int w;
        bit hs;
        w = 0;
        @(negedge clk);
        i_valid  = 1'b1;
        i_is_num = num;
        i_data   = d;
        hs = 1'b0;
        while (!hs && w <= 300) begin
            hs = i_ready;
            @(posedge clk);
            if (!hs) begin
                w++;
                @(negedge clk);
            end
        end
        if (!hs) chk("input_accept_timeout", 32'd0, 32'd1);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_busy || o_valid) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_reached", {31'd0, (w < 1000)}, 32'd1);
    endtask

    task automatic run_expr(input string d, input string k, input string pd, input string pk,
                            input logic [7:0] endtok, input bit gaps);
        push_expected(pd, pk, endtok);
        for (int i = 0; i < d.len(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            drive_tok(k[i] == 8'h6E, d[i]);
        end
        drive_tok(1'b0, 8'h3D);
        wait_idle();
    endtask

    task automatic gen_random(output string d, output string k, output string pd, output string pk);
        byte unsigned ops[4];
        byte unsigned op[32];
        byte unsigned val[32];
        int           lc[32];
        int           rc[32];
        string        sd[32], sk[32], spd[32], spk[32];
        string        ld, lk, rd, rk;
        int           n, nexp, leaf, l, r;
        ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h2A; ops[3] = 8'h2F;
        n = 1;
        op[0] = 0;
        val[0] = 8'($urandom_range(1, 255));
        nexp = $urandom_range(0, 8);
        for (int e = 0; e < nexp; e++) begin
            leaf = $urandom_range(0, n - 1);
            while (op[leaf] != 0) leaf = $urandom_range(0, n - 1);
            op[leaf]   = ops[$urandom_range(0, 3)];
            lc[leaf]   = n;
            rc[leaf]   = n + 1;
            op[n]      = 0;
            op[n + 1]  = 0;
            val[n]     = 8'($urandom_range(1, 255));
            val[n + 1] = 8'($urandom_range(1, 255));
            n += 2;
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (op[i] == 0) begin
                sd[i]  = $sformatf("%c", val[i]);
                sk[i]  = "n";
                spd[i] = sd[i];
                spk[i] = "n";
            end else begin
                l = lc[i];
                r = rc[i];
                ld = sd[l]; lk = sk[l]; rd = sd[r]; rk = sk[r];
                if ((op[l] != 0 && tprec(op[l]) < tprec(op[i])) || $urandom_range(0, 4) == 0) begin
                    ld = {"(", ld, ")"}; lk = {"o", lk, "o"};
                end
                if ((op[r] != 0 && tprec(op[r]) <= tprec(op[i])) || $urandom_range(0, 4) == 0) begin
                    rd = {"(", rd, ")"}; rk = {"o", rk, "o"};
                end
                sd[i]  = {ld, $sformatf("%c", op[i]), rd};
                sk[i]  = {lk, "o", rk};
                spd[i] = {spd[l], spd[r], $sformatf("%c", op[i])};
                spk[i] = {spk[l], spk[r], "o"};
            end
        end
        d = sd[0]; k = sk[0]; pd = spd[0]; pk = spk[0];
    endtask

    initial begin
        string d, k, pd, pk, p, pko;
        int    w;
        rst = 1'b1;
        i_valid = 1'b0;
        i_is_num = 1'b0;
        i_data = 8'h00;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_i_ready",  {31'd0, i_ready},  32'd0);
        chk("rst_o_valid",  {31'd0, o_valid},  32'd0);
        chk("rst_o_is_num", {31'd0, o_is_num}, 32'd0);
        chk("rst_o_data",   {24'd0, o_data},   32'd0);
        chk("rst_o_busy",   {31'd0, o_busy},   32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, i_ready}, 32'd1);

        // 3 + 4 * 2 = with latency and ready-drop probes.
        push_expected($sformatf("%c%c%c*+", 3, 4, 2), "nnnoo", 8'h3D);
        drive_tok(1'b1, 8'd3);
        @(negedge clk);
        chk("operand_latency", {23'd0, o_valid, o_is_num, o_data}, {23'd0, 1'b1, 1'b1, 8'd3});
        drive_tok(1'b0, 8'h2B);
        @(negedge clk);
        chk("ready_in_reduce", {31'd0, i_ready}, 32'd0);
        drive_tok(1'b1, 8'd4);
        drive_tok(1'b0, 8'h2A);
        drive_tok(1'b1, 8'd2);
        drive_tok(1'b0, 8'h3D);
        @(negedge clk);
        chk("ready_in_drain", {30'd0, i_ready, o_busy}, {30'd0, 1'b0, 1'b1});
        wait_idle();

        run_expr($sformatf("(%c+%c)*%c", 1, 2, 3), "ononoon",
                 $sformatf("%c%c+%c*", 1, 2, 3), "nnono", 8'h3D, 1'b0);
        run_expr($sformatf("%c-%c-%c", 8, 3, 2), "nonon",
                 $sformatf("%c%c-%c-", 8, 3, 2), "nnono", 8'h3D, 1'b0);
        rdy_mode = 1;
        run_expr($sformatf("%c+%c*%c", 3, 4, 2), "nonon",
                 $sformatf("%c%c%c*+", 3, 4, 2), "nnnoo", 8'h3D, 1'b0);
        rdy_mode = 0;
        run_expr($sformatf("%c)", 5), "no", $sformatf("%c", 5), "n", BAD_END, 1'b0);
        run_expr($sformatf("%cA+%c", 2, 3), "noon", $sformatf("%c%c+", 2, 3), "nno", 8'h3D, 1'b0);

        // Stack filled to exactly 63 entries, then one push beyond it.
        p = ""; pko = "";
        for (int i = 0; i < 61; i++) begin p = {p, "("}; pko = {pko, "o"}; end
        run_expr({p, $sformatf("%c+%c*%c", 1, 2, 3)}, {pko, "nonon"},
                 $sformatf("%c%c%c*+", 1, 2, 3), "nnnoo", BAD_END, 1'b0);
        p = {p, "("}; pko = {pko, "o"};
        run_expr({p, $sformatf("%c+%c*%c", 1, 2, 3)}, {pko, "nonon"},
                 $sformatf("%c%c%c+", 1, 2, 3), "nnno", BAD_END, 1'b0);

        // Reset in the middle of 1 + ( 2.
        exp_q.push_back({1'b1, 8'd1});
        exp_q.push_back({1'b1, 8'd2});
        drive_tok(1'b1, 8'd1);
        drive_tok(1'b0, 8'h2B);
        drive_tok(1'b0, 8'h28);
        drive_tok(1'b1, 8'd2);
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
        chk("partial_drained", {31'd0, (w < 200)}, 32'd1);
        @(negedge clk);
        chk("busy_mid_expr", {31'd0, o_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_o_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_o_busy",  {31'd0, o_busy},  32'd0);
        chk("abort_i_ready", {31'd0, i_ready}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_expr($sformatf("%c", 7), "n", $sformatf("%c", 7), "n", 8'h3D, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rdy_mode = $urandom_range(0, 2);
            gen_random(d, k, pd, pk);
            run_expr(d, k, pd, pk, 8'h3D, 1'b1);
        end

        rdy_mode = 0;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
